connect4_turn_ctrl: RTL

- Upstream input and turn stage for the Connect4 board block.
- Conditions the raw drop button and column switches, and rejects illegal moves (column 7, full column).
- Emits a one-cycle load pulse with a stable column and current player to the board.
- Consumes the board's win output to end the game, and tracks move count and draw.

---
 rtl/connect4_turn_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/connect4_turn_ctrl.sv
// Turn controller for the Connect4 board: conditions the drop button and column
// switches, screens illegal moves and sequences one load strobe per accepted press.
module connect4_turn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int WIN_LATENCY     = 2,
    parameter int ROWS            = 6,
    parameter int COLS            = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [2:0] col_sw,
    input  logic       win,
    output logic       load_btn,
    output logic [2:0] column,
    output logic       player,
    output logic [5:0] move_count,
    output logic       illegal,
    output logic       game_over,
    output logic       winner,
    output logic       draw
);

    // state    | meaning
    // IDLE     | waiting for a synchronized press
    // DEBOUNCE | button must stay high DEBOUNCE_CYCLES before acceptance
    // CHECK    | column latched; screen for out-of-range or full column
    // ISSUE    | load_btn high for this single cycle
    // SETTLE   | wait WIN_LATENCY cycles, then sample the board's win
    // RELEASE  | wait for button release so a held press counts once
    // OVER     | game ended; hold outputs until reset
    typedef enum logic [2:0] {IDLE, DEBOUNCE, CHECK, ISSUE, SETTLE, RELEASE, OVER} state_t;

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > WIN_LATENCY) ? DEBOUNCE_CYCLES : WIN_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        state;
    logic          btn_m, btn_s;
    logic [2:0]    col_m, col_s;
    logic [CW-1:0] cnt;
    logic [2:0]    height [8];
    logic          col_ok, col_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            col_m <= 3'd0;
            col_s <= 3'd0;
        end else begin
            btn_m <= btn_raw;
            btn_s <= btn_m;
            col_m <= col_sw;
            col_s <= col_m;
        end
    end

    assign col_ok   = ({1'b0, column} < 4'(COLS));
    assign col_full = (height[column] >= 3'(ROWS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            load_btn   <= 1'b0;
            column     <= 3'd0;
            player     <= 1'b0;
            move_count <= 6'd0;
            illegal    <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
            draw       <= 1'b0;
            for (int i = 0; i < 8; i++) height[i] <= 3'd0;
        end else begin
            load_btn <= 1'b0;
            illegal  <= 1'b0;
            // An unsolicited win ends the game; credit the player of the last completed move.
            if (win && state != SETTLE && state != OVER) begin
                game_over <= 1'b1;
                winner    <= (state == ISSUE) ? player : ~player;
                state     <= OVER;
            end else begin
                case (state)
                    IDLE: begin
                        if (btn_s) begin
                            cnt   <= '0;
                            state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (!btn_s) begin
                            state <= IDLE;
                        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                            column <= col_s;
                            state  <= CHECK;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    CHECK: begin
                        if (!col_ok || col_full) begin
                            illegal <= 1'b1;
                            state   <= RELEASE;
                        end else begin
                            load_btn       <= 1'b1;
                            height[column] <= height[column] + 3'd1;
                            move_count     <= move_count + 6'd1;
                            state          <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                    SETTLE: begin
                        if (cnt == CW'(WIN_LATENCY - 1)) begin
                            if (win) begin
                                game_over <= 1'b1;
                                winner    <= player;
                                state     <= OVER;
                            end else if (move_count == 6'(ROWS * COLS)) begin
                                game_over <= 1'b1;
                                draw      <= 1'b1;
                                state     <= OVER;
                            end else begin
                                player <= ~player;
                                state  <= RELEASE;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RELEASE: begin
                        if (!btn_s) state <= IDLE;
                    end
                    OVER: state <= OVER;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
